rs_rotate_accum: RTL and testbench

- Pipelined, multi-lane successor of the 8-PSK R·s rotation multiplier used in the sphere-decoder L1-norm path.
- Each beat carries LANES complex R entries, each with a 3-bit 8-PSK symbol index.
- The block rotates each entry by its symbol, sums the lanes, and accumulates across beats of a frame.
- It emits one complex partial-metric term per frame (framed by in_last), with valid/ready flow control on both sides.

---
 rtl/rs_pkg.sv | 33 +++
 rtl/rs_lane_rotate.sv | 59 +++++
 rtl/rs_rotate_accum.sv | 126 ++++++++++++
 tb/tb_rs_rotate_accum.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared constants, frame-state type and saturation helper for rs_rotate_accum
package rs_pkg;

  localparam logic [2:0] S_0DEG = 3'd7;
  localparam logic [2:0] S_45   = 3'd6;
  localparam logic [2:0] S_90   = 3'd2;
  localparam logic [2:0] S_135  = 3'd3;
  localparam logic [2:0] S_180  = 3'd1;
  localparam logic [2:0] S_225  = 3'd0;
  localparam logic [2:0] S_270  = 3'd4;
  localparam logic [2:0] S_315  = 3'd5;

  localparam int FRAC_DEF = 8;
  localparam int COEF_DEF = 181;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } frame_state_e;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/rs_lane_rotate.sv
// rtl/rs_lane_rotate.sv - combinational single-lane 8-PSK rotate and saturate
// RS_ROUND_EN: diagonal products round half up instead of flooring.
module rs_lane_rotate
  import rs_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int FRAC  = FRAC_DEF,
  parameter int COEF  = COEF_DEF
) (
  input  logic signed [WIDTH-1:0] i_re,
  input  logic signed [WIDTH-1:0] i_im,
  input  logic [2:0]              i_s,
  output logic signed [WIDTH-1:0] o_re,
  output logic signed [WIDTH-1:0] o_im
);

  // Wide enough for -(a+b) at full scale times the 9-bit coefficient.
  localparam int PW = WIDTH + 12;

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_x_re;
  logic signed [PW-1:0] w_x_im;

  function automatic logic signed [PW-1:0] scale(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] p;
    p = v * PW'(COEF);
`ifdef RS_ROUND_EN
    p = p + (PW'(1) <<< (FRAC - 1));
`else
    p = p + PW'(0);
`endif
    return p >>> FRAC;
  endfunction

  assign w_a = PW'(i_re);
  assign w_b = PW'(i_im);

  // Negation happens before scaling so the floor direction follows the rotated value.
  always_comb begin
    w_x_re = w_a;
    w_x_im = w_b;
    case (i_s)
      S_0DEG: begin w_x_re = w_a;                w_x_im = w_b;                end
      S_45:   begin w_x_re = scale(w_a - w_b);   w_x_im = scale(w_a + w_b);   end
      S_90:   begin w_x_re = -w_b;               w_x_im = w_a;                end
      S_135:  begin w_x_re = scale(-w_a - w_b);  w_x_im = scale(w_a - w_b);   end
      S_180:  begin w_x_re = -w_a;               w_x_im = -w_b;               end
      S_225:  begin w_x_re = scale(w_b - w_a);   w_x_im = scale(-w_a - w_b);  end
      S_270:  begin w_x_re = w_b;                w_x_im = -w_a;               end
      S_315:  begin w_x_re = scale(w_a + w_b);   w_x_im = scale(w_b - w_a);   end
      default: begin w_x_re = w_a;               w_x_im = w_b;                end
    endcase
  end

  assign o_re = WIDTH'(sat(64'(w_x_re), WIDTH));
  assign o_im = WIDTH'(sat(64'(w_x_im), WIDTH));

endmodule

// File: rtl/rs_rotate_accum.sv
// rtl/rs_rotate_accum.sv - multi-lane 8-PSK rotate, lane sum and per-frame accumulate
module rs_rotate_accum
  import rs_pkg::*;
#(
  parameter  int WIDTH = 20,
  parameter  int LANES = 4,
  parameter  int FRAC  = FRAC_DEF,
  parameter  int COEF  = COEF_DEF,
  parameter  int GUARD = 4,
  localparam int OUT_W = WIDTH + $clog2(LANES) + GUARD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*LANES-1:0]   in_r_real,
  input  logic [WIDTH*LANES-1:0]   in_r_imag,
  input  logic [3*LANES-1:0]       in_s,
  input  logic [LANES-1:0]         in_mask,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_real,
  output logic signed [OUT_W-1:0]  out_imag
);

  logic                    w_en;
  logic                    w_open;
  logic                    w_out_valid;
  logic signed [WIDTH-1:0] w_rot_re [LANES];
  logic signed [WIDTH-1:0] w_rot_im [LANES];
  logic signed [OUT_W-1:0] w_sum_re;
  logic signed [OUT_W-1:0] w_sum_im;
  frame_state_e            w_state_nxt;

  logic                    r_v1;
  logic                    r_last1;
  logic signed [WIDTH-1:0] r_re1 [LANES];
  logic signed [WIDTH-1:0] r_im1 [LANES];
  logic signed [OUT_W-1:0] r_acc_re;
  logic signed [OUT_W-1:0] r_acc_im;
  frame_state_e            r_state;

  // A held result freezes the whole pipeline, including input acceptance.
  assign w_en     = !w_out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rs_lane_rotate #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .COEF  (COEF)
    ) u_rot (
      .i_re (in_r_real[k*WIDTH +: WIDTH]),
      .i_im (in_r_imag[k*WIDTH +: WIDTH]),
      .i_s  (in_s[3*k +: 3]),
      .o_re (w_rot_re[k]),
      .o_im (w_rot_im[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_re1[k] <= '0;
        r_im1[k] <= '0;
      end
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_last1 <= in_valid && in_last;
      for (int k = 0; k < LANES; k++) begin
        r_re1[k] <= (in_valid && in_mask[k]) ? w_rot_re[k] : '0;
        r_im1[k] <= (in_valid && in_mask[k]) ? w_rot_im[k] : '0;
      end
    end
  end

  always_comb begin
    w_sum_re = '0;
    w_sum_im = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum_re = w_sum_re + OUT_W'(r_re1[k]);
      w_sum_im = w_sum_im + OUT_W'(r_im1[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_en && r_v1) begin
      w_state_nxt = r_last1 ? ST_HOLD : ST_ACCUM;
    end else if (w_en && (r_state == ST_HOLD)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_open      = (r_state == ST_ACCUM);
    w_out_valid = (r_state == ST_HOLD);
  end

  // The accumulator wraps silently; GUARD bits set how many full-scale beats fit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else if (w_en && r_v1) begin
      r_acc_re <= w_open ? (r_acc_re + w_sum_re) : w_sum_re;
      r_acc_im <= w_open ? (r_acc_im + w_sum_im) : w_sum_im;
    end
  end

  assign out_valid = w_out_valid;
  assign out_real  = r_acc_re;
  assign out_imag  = r_acc_im;

endmodule

// File: tb/tb_rs_rotate_accum.sv
// tb/tb_rs_rotate_accum.sv - self-checking bench for rs_rotate_accum (vector table, corner sequences, random frames)
module tb_rs_rotate_accum;

  localparam int WIDTH = 20;
  localparam int LANES = 4;
  localparam int FRAC  = 8;
  localparam int COEF  = 181;
  localparam int GUARD = 4;
  localparam int OUT_W = WIDTH + $clog2(LANES) + GUARD;
  localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
  localparam longint MINV = -MAXV - 1;
`ifdef RS_ROUND_EN
  localparam bit     ROUND = 1'b1;
  localparam longint RND   = 64'sd1 <<< (FRAC - 1);
`else
  localparam bit     ROUND = 1'b0;
  localparam longint RND   = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WIDTH*LANES-1:0]  in_r_real = '0;
  logic [WIDTH*LANES-1:0]  in_r_imag = '0;
  logic [3*LANES-1:0]      in_s = '0;
  logic [LANES-1:0]        in_mask = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_real;
  logic signed [OUT_W-1:0] out_imag;

  int     n_vec = 0;
  int     n_err = 0;
  longint exp_re_q[$];
  longint exp_im_q[$];
  bit     rand_ready = 1'b0;
  bit     ready_force = 1'b1;

  typedef struct {
    longint re;
    longint im;
    int     s;
    longint ere;
    longint eim;
  } vec_t;

  vec_t tbl[10];

  rs_rotate_accum #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .FRAC  (FRAC),
    .COEF  (COEF),
    .GUARD (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r_real (in_r_real),
    .in_r_imag (in_r_imag),
    .in_s      (in_s),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every accepted result is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_re_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got (%0d,%0d), expected no result", out_real, out_imag);
      end else begin
        chk("out_real", out_real, exp_re_q.pop_front());
        chk("out_imag", out_imag, exp_im_q.pop_front());
      end
    end
  end

  function automatic longint sat_ref(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint wrap_ref(input longint x);
    logic signed [OUT_W-1:0] t;
    t = OUT_W'(x);
    return t;
  endfunction

  // Complex multiply by the unit phasor of symbol s; diagonal phasors carry a 1/sqrt2 factor.
  task automatic ref_rot(input longint a, input longint b, input int s,
                         output longint re, output longint im);
    longint cr, ci;
    bit     diag;
    case (s)
      7: begin cr =  1; ci =  0; diag = 0; end
      6: begin cr =  1; ci =  1; diag = 1; end
      2: begin cr =  0; ci =  1; diag = 0; end
      3: begin cr = -1; ci =  1; diag = 1; end
      1: begin cr = -1; ci =  0; diag = 0; end
      0: begin cr = -1; ci = -1; diag = 1; end
      4: begin cr =  0; ci = -1; diag = 0; end
      default: begin cr = 1; ci = -1; diag = 1; end
    endcase
    re = a * cr - b * ci;
    im = a * ci + b * cr;
    if (diag) begin
      re = (re * COEF + RND) >>> FRAC;
      im = (im * COEF + RND) >>> FRAC;
    end
    re = sat_ref(re);
    im = sat_ref(im);
  endtask

  function automatic longint rnd_val();
    logic signed [WIDTH-1:0] t;
    case ($urandom_range(0, 7))
      0:       t = WIDTH'(MAXV);
      1:       t = WIDTH'(MINV);
      default: t = WIDTH'($urandom);
    endcase
    return t;
  endfunction

  task automatic drive_beat(input logic [WIDTH*LANES-1:0] re, input logic [WIDTH*LANES-1:0] im,
                            input logic [3*LANES-1:0] s, input logic [LANES-1:0] m, input logic last);
    int  n = 0;
    bit  ok = 0;
    in_r_real = re;
    in_r_imag = im;
    in_s      = s;
    in_mask   = m;
    in_last   = last;
    in_valid  = 1'b1;
    while (!ok && n < 200) begin
      #1;
      if (in_ready) ok = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    else @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_re_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_re_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d results outstanding, expected 0", name, exp_re_q.size());
      exp_re_q.delete();
      exp_im_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH*LANES-1:0] vre, vim;
    logic [3*LANES-1:0]     vs;
    logic [LANES-1:0]       vm;
    longint                 fre, fim, lre, lim;
    int                     nb, wt;

    tbl[0] = '{256, 0, 6, 181, 181};
    tbl[1] = '{256, 0, 4, 0, -256};
    tbl[2] = '{524287, 524287, 6, 0, 524287};
    tbl[3] = '{-524288, 0, 1, 524287, 0};
    tbl[4] = '{1, 0, 6, ROUND ? 1 : 0, ROUND ? 1 : 0};
    tbl[5] = '{1, 0, 0, -1, -1};
    tbl[6] = '{100, -50, 2, 50, 100};
    tbl[7] = '{100, -50, 3, ROUND ? -35 : -36, 106};
    tbl[8] = '{-524288, 0, 4, 0, 524287};
    tbl[9] = '{-524288, -524288, 5, -524288, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_real", out_real, 0);
    chk("reset_out_imag", out_imag, 0);
    chk("reset_in_ready_after", in_ready, 1);
    @(negedge clk);

    // All four lanes pass through unrotated; result appears exactly two edges after presentation.
    for (int k = 0; k < LANES; k++) begin
      vre[k*WIDTH +: WIDTH] = WIDTH'(100);
      vim[k*WIDTH +: WIDTH] = WIDTH'(-50);
      vs[3*k +: 3] = 3'd7;
    end
    exp_re_q.push_back(400);
    exp_im_q.push_back(-200);
    drive_beat(vre, vim, vs, 4'b1111, 1'b1);
    #1;
    chk("latency_not_early", out_valid, 0);
    @(negedge clk);
    #1;
    chk("latency_valid", out_valid, 1);
    chk("latency_real", out_real, 400);
    chk("latency_imag", out_imag, -200);
    @(negedge clk);
    #1;
    chk("single_cycle_valid", out_valid, 0);
    drain("all_lanes");

    // Lane 0 only; other lanes carry random data that the mask must suppress.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < LANES; k++) begin
        vre[k*WIDTH +: WIDTH] = WIDTH'(rnd_val());
        vim[k*WIDTH +: WIDTH] = WIDTH'(rnd_val());
        vs[3*k +: 3] = 3'($urandom);
      end
      vre[WIDTH-1:0] = WIDTH'(tbl[i].re);
      vim[WIDTH-1:0] = WIDTH'(tbl[i].im);
      vs[2:0] = 3'(tbl[i].s);
      exp_re_q.push_back(tbl[i].ere);
      exp_im_q.push_back(tbl[i].eim);
      drive_beat(vre, vim, vs, 4'b0001, 1'b1);
      drain("table");
    end

    // Three-beat frame held under back-pressure.
    #1;
    ready_force = 1'b0;
    vre = '0;
    vim = '0;
    vs  = '0;
    vre[WIDTH-1:0] = WIDTH'(10);
    vs[2:0] = 3'd7;
    exp_re_q.push_back(30);
    exp_im_q.push_back(0);
    drive_beat(vre, vim, vs, 4'b0001, 1'b0);
    drive_beat(vre, vim, vs, 4'b0001, 1'b0);
    drive_beat(vre, vim, vs, 4'b0001, 1'b1);
    wt = 0;
    #1;
    while (!out_valid && wt < 20) begin
      @(negedge clk);
      #1;
      wt++;
    end
    chk("hold_valid_rise", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_real", out_real, 30);
      chk("hold_imag", out_imag, 0);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
      #1;
    end
    ready_force = 1'b1;
    drain("hold");

    // Reset in the middle of an open frame; only the following frame may appear.
    vre = '0;
    vim = '0;
    vre[WIDTH-1:0] = WIDTH'(50);
    vim[WIDTH-1:0] = WIDTH'(50);
    drive_beat(vre, vim, vs, 4'b0001, 1'b0);
    drive_beat(vre, vim, vs, 4'b0001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    vre[WIDTH-1:0] = WIDTH'(7);
    vim[WIDTH-1:0] = WIDTH'(3);
    exp_re_q.push_back(7);
    exp_im_q.push_back(3);
    drive_beat(vre, vim, vs, 4'b0001, 1'b1);
    drain("abort");

    // Random multi-beat frames under random back-pressure, checked against the phasor model.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nb  = $urandom_range(1, 4);
      fre = 0;
      fim = 0;
      for (int b = 0; b < nb; b++) begin
        vm = LANES'($urandom);
        for (int k = 0; k < LANES; k++) begin
          lre = rnd_val();
          lim = rnd_val();
          vs[3*k +: 3] = 3'($urandom);
          vre[k*WIDTH +: WIDTH] = WIDTH'(lre);
          vim[k*WIDTH +: WIDTH] = WIDTH'(lim);
          if (vm[k]) begin
            ref_rot(lre, lim, int'(vs[3*k +: 3]), lre, lim);
            fre += lre;
            fim += lim;
          end
        end
        if (b == nb - 1) begin
          exp_re_q.push_back(wrap_ref(fre));
          exp_im_q.push_back(wrap_ref(fim));
        end
        drive_beat(vre, vim, vs, vm, b == nb - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain("random");
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
